ps2_rx_frame: RTL

PS/2 device-to-host receive front end that turns the raw keyboard `ps2c`/`ps2d` lines into validated scan-code bytes. It sits directly upstream of the keyboard scan-code/display logic and feeds it one byte per accepted frame over a valid/ready handshake. It handles:
- synchronisation and glitch filtering of the PS/2 clock,
- 11-bit frame assembly,
- odd-parity and stop-bit checking,
- inter-bit timeout and overrun reporting.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_line_filter.sv | 35 +++
 rtl/ps2_rx_frame.sv | 95 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame constants, FSM state encoding and parity helper for the PS/2 receiver
package ps2_pkg;
    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;
    typedef logic [1:0] ps2_state_t;
    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;
    function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizes ps2c/ps2d, debounces ps2c and flags its falling edges
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c,
    input  logic ps2d,
    output logic fclk,
    output logic fall,
    output logic sdata
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0] c_sync, d_sync;
    logic [CW-1:0] cnt;
    logic change, settle;
    assign sdata  = d_sync[1];
    assign change = c_sync[1] != fclk;
    assign settle = change && cnt == CW'(FILTER_LEN - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            fclk   <= 1'b1;
            fall   <= 1'b0;
            cnt    <= '0;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            fall   <= settle && fclk;
            fclk   <= settle ? c_sync[1] : fclk;
            cnt    <= (change && !settle) ? cnt + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: assembles PS/2 frames, checks stop/parity/timeout and holds one byte for a valid/ready consumer
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       err_overrun
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);
    ps2_state_t state;
    logic [BW-1:0] bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic par;
    logic [TW-1:0] tmo;
    logic fall, sdata, fclk_unused;
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk  (clk),
        .rst  (rst),
        .ps2c (ps2c),
        .ps2d (ps2d),
        .fclk (fclk_unused),
        .fall (fall),
        .sdata(sdata)
    );
    assign rx_busy = state != ST_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            tmo         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            tmo <= rx_busy ? tmo + 1'b1 : '0;
            // tmo restarts at 1 so err_timeout lands exactly TIMEOUT_CYCLES after the last fall
            if (fall) begin
                tmo <= TW'(1);
                case (state)
                    ST_IDLE: begin
                        if (sdata) err_frame <= 1'b1;
                        else begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {sdata, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= sdata;
                        state <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (!sdata) err_frame <= 1'b1;
                        else if (par != ps2_odd_parity(shreg)) err_parity <= 1'b1;
                        else if (!rx_valid || rx_ready) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else err_overrun <= 1'b1;
                    end
                endcase
            end else if (rx_busy && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                state       <= ST_IDLE;
                err_timeout <= 1'b1;
            end
        end
    end
endmodule
